// File: rtl/seq_divider.sv
// Iterative 32/32 restoring divider: one shift or subtract step per clock, {remainder, quotient} on a 64-bit bus.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement signed division; the default build is unsigned.
module seq_divider (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_op_start,
  input  logic        i_op_clear,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_op_done,
  output logic [63:0] o_result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_CALC  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [4:0]  r_count;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [33:0] w_diff;
  logic [31:0] w_dividend_mag;
  logic [31:0] w_divisor_mag;
  logic        w_dividend_neg;
  logic        w_divisor_neg;

  function automatic logic [31:0] f_abs(input logic [31:0] v);
    f_abs = v[31] ? (32'd0 - v) : v;
  endfunction

`ifdef DIVIDER_SIGNED_EN
  assign w_dividend_mag = f_abs(i_dividend);
  assign w_divisor_mag  = f_abs(i_divisor);
  assign w_dividend_neg = i_dividend[31];
  assign w_divisor_neg  = i_divisor[31];
`else
  assign w_dividend_mag = i_dividend;
  assign w_divisor_mag  = i_divisor;
  assign w_dividend_neg = 1'b0;
  assign w_divisor_neg  = 1'b0;
`endif

  // rem carries a 33rd bit so divisors above 2^31 keep the bit shifted out of rem.
  assign w_diff = {1'b0, r_rem} - {2'b00, r_div};

  // State register: reset, then op_clear, then next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else if (i_op_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_op_start) begin
          w_next_state = (i_divisor == 32'd0) ? S_DONE : S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: w_next_state = S_CALC;
      S_CALC: begin
        if (r_count == 5'd31) begin
          w_next_state = S_FIX;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_op_clear) begin
      r_rem     <= 33'd0;
      r_quo     <= 32'd0;
      r_div     <= 32'd0;
      r_count   <= 5'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      o_op_done <= 1'b0;
      o_result  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_op_done <= 1'b0;
          if (i_op_start) begin
            r_div   <= w_divisor_mag;
            r_neg_q <= w_dividend_neg ^ w_divisor_neg;
            r_neg_r <= w_dividend_neg;
            r_count <= 5'd0;
            if (i_divisor == 32'd0) begin
              r_rem <= {1'b0, i_dividend};
              r_quo <= 32'hFFFF_FFFF;
            end else begin
              r_rem <= 33'd0;
              r_quo <= w_dividend_mag;
            end
          end
        end
        S_SHIFT: begin
          r_rem <= {r_rem[31:0], r_quo[31]};
          r_quo <= {r_quo[30:0], 1'b0};
        end
        S_CALC: begin
          if (!w_diff[33]) begin
            r_rem    <= w_diff[32:0];
            r_quo[0] <= 1'b1;
          end
          if (r_count != 5'd31) begin
            r_count <= r_count + 5'd1;
          end
        end
        S_FIX: begin
          if (r_neg_q) begin
            r_quo <= 32'd0 - r_quo;
          end
          if (r_neg_r) begin
            r_rem <= {1'b0, 32'd0 - r_rem[31:0]};
          end
        end
        S_DONE: begin
          o_result  <= {r_rem[31:0], r_quo};
          o_op_done <= 1'b1;
        end
        default: begin
          o_op_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider; expected values are hand-computed for both the signed and unsigned build.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_op_start;
  logic        i_op_clear;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_op_done;
  logic [63:0] o_result;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_op_start (i_op_start),
    .i_op_clear (i_op_clear),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_op_done  (o_op_done),
    .o_result   (o_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept at E0, then scramble operands to prove they are not resampled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    i_dividend = a;
    i_divisor  = b;
    i_op_start = 1'b1;
    tick();
    i_op_start = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
  endtask

  // Caller has just passed E0: op_done must be low after E65 and high with the result after E66.
  task automatic expect_done(input string tag, input logic [63:0] exp);
    repeat (65) tick();
    check({tag, "_busy_e65"}, {63'd0, o_op_done}, 64'd0);
    tick();
    check({tag, "_done_e66"}, {63'd0, o_op_done}, 64'd1);
    check({tag, "_result"}, o_result, exp);
  endtask

  task automatic clear();
    i_op_clear = 1'b1;
    tick();
    i_op_clear = 1'b0;
    check("clear_done", {63'd0, o_op_done}, 64'd0);
    check("clear_result", o_result, 64'd0);
  endtask

  initial begin
    i_reset    = 1'b1;
    i_op_start = 1'b0;
    i_op_clear = 1'b0;
    i_dividend = 32'd0;
    i_divisor  = 32'd0;
    tick();
    tick();
    i_reset = 1'b0;
    check("reset_done", {63'd0, o_op_done}, 64'd0);
    check("reset_result", o_result, 64'd0);

    // 100 / 7, then hold 10 cycles with op_start pulsing (ignored in DONE)
    start_op(32'd100, 32'd7);
    expect_done("div_100_7", 64'h00000002_0000000E);
    for (int i = 0; i < 10; i++) begin
      i_op_start = i[0];
      i_dividend = 32'd9;
      i_divisor  = 32'd2;
      tick();
      check("hold_done", {63'd0, o_op_done}, 64'd1);
      check("hold_result", o_result, 64'h00000002_0000000E);
    end
    i_op_start = 1'b0;

    // reset from DONE clears the held result
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("reset_from_done_done", {63'd0, o_op_done}, 64'd0);
    check("reset_from_done_result", o_result, 64'd0);

    start_op(32'hFFFF_FF9C, 32'd7);
`ifdef DIVIDER_SIGNED_EN
    expect_done("div_m100_7", 64'hFFFFFFFE_FFFFFFF2);
`else
    expect_done("div_m100_7", 64'h00000002_24924916);
`endif
    clear();

    start_op(32'd100, 32'hFFFF_FFF9);
`ifdef DIVIDER_SIGNED_EN
    expect_done("div_100_m7", 64'h00000002_FFFFFFF2);
`else
    expect_done("div_100_m7", 64'h00000064_00000000);
`endif
    clear();

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
`ifdef DIVIDER_SIGNED_EN
    expect_done("div_ovf", 64'h00000000_80000000);
`else
    expect_done("div_ovf", 64'h80000000_00000000);
`endif
    clear();

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFE);
`ifdef DIVIDER_SIGNED_EN
    expect_done("div_big", 64'hFFFFFFFF_00000000);
`else
    expect_done("div_big", 64'h00000001_00000001);
`endif
    clear();

    start_op(32'd7, 32'd100);
    expect_done("div_small", 64'h00000007_00000000);
    clear();

    // divide by zero: done after E1
    start_op(32'd12345, 32'd0);
    check("dbz_e0_done", {63'd0, o_op_done}, 64'd0);
    tick();
    check("dbz_e1_done", {63'd0, o_op_done}, 64'd1);
    check("dbz_result", o_result, 64'h00003039_FFFFFFFF);
    clear();

    // op_clear at E21 aborts, then 20 / 3 starts on the next edge
    start_op(32'd100, 32'd7);
    repeat (20) tick();
    i_op_clear = 1'b1;
    tick();
    i_op_clear = 1'b0;
    check("abort_done", {63'd0, o_op_done}, 64'd0);
    check("abort_result", o_result, 64'd0);
    start_op(32'd20, 32'd3);
    expect_done("div_20_3", 64'h00000002_00000006);
    clear();

    // reset at E40 with op_start held high throughout
    i_dividend = 32'd100;
    i_divisor  = 32'd7;
    i_op_start = 1'b1;
    tick();
    repeat (39) tick();
    i_reset = 1'b1;
    tick();
    check("rst_e40_done", {63'd0, o_op_done}, 64'd0);
    check("rst_e40_result", o_result, 64'd0);
    i_reset    = 1'b0;
    i_dividend = 32'd20;
    i_divisor  = 32'd3;
    tick();
    i_op_start = 1'b0;
    i_dividend = 32'd1;
    i_divisor  = 32'd1;
    expect_done("after_rst", 64'h00000002_00000006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative 32-bit restoring divider; the inverse datapath companion to the team's sequential Booth multiplier.
- Uses the same op_start/op_clear/op_done handshake and the same 64-bit result bus, so the ALU wrapper can drive either unit interchangeably.
- Returns quotient and remainder, with one shift or subtract step per clock.

Parameters:
- None. Width is fixed at 32/32 -> {remainder, quotient} 64 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_start  input  1  start request; sampled only in IDLE.
- op_clear  input  1  synchronous clear of all state and outputs; highest priority after reset.
- dividend  input  32  numerator; sampled only on the accepting edge.
- divisor  input  32  denominator; sampled only on the accepting edge.
- op_done  output  1  high while a valid result is held.
- result  output  64  result[63:32] = remainder, result[31:0] = quotient.

Behaviour:
- Priority at each edge: reset, then op_clear, then the FSM.
- reset or op_clear: state <= IDLE; op_done, result, all internal registers <= 0.
- States:
  - IDLE: op_done <= 0.
    - On op_start: latch operand magnitudes and signs; rem <= 0; quo <= |dividend|; count <= 0.
    - If divisor == 0, go to DONE. Otherwise go to SHIFT.
  - SHIFT: {rem, quo} <= {rem, quo} << 1; go to CALC.
  - CALC: diff = {1'b0, rem} - {1'b0, |divisor|}, computed 33 bits wide.
    - If diff >= 0: rem <= diff[31:0], quo[0] <= 1. Otherwise registers are unchanged (restore).
    - If count == 31, go to FIX; else count++ and go to SHIFT.
  - FIX: sign correction.
    - Quotient is negated if sign(dividend) != sign(divisor).
    - Remainder is negated if dividend is negative.
    - Go to DONE.
  - DONE: result <= {rem, quo}; op_done <= 1. Holds until op_clear; op_start is ignored here.
- Latency: op_start sampled at edge E0; op_done and result valid after E66 (1 load + 32x(SHIFT+CALC) + FIX + DONE).
- Divide by zero: at E0 preload quo = 32'hFFFFFFFF and rem = dividend, then go to DONE. op_done is high after E1.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign. |divisor| of 32'h80000000 is treated as unsigned 2^31.
- Overflow: 32'h80000000 / 32'hFFFFFFFF (signed) gives quotient 32'h80000000, remainder 0. No flag is raised.
- op_start held high across DONE and back into IDLE after op_clear: accepted on the first IDLE edge at which op_clear is low.
- op_clear or reset during any busy state aborts the operation. No partial result appears and op_done stays 0.
- Operand inputs may change freely after E0 without effect.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: two's-complement signed division as described above.
- Undefined: operands are unsigned.
  - Magnitude = raw value; FIX passes values through unchanged.
  - FIX state still consumes one cycle, so latency stays 66.
  - Divide by zero still gives quotient 32'hFFFFFFFF, remainder = dividend.

Test Plan:
- 100 / 7 -> result = 64'h00000002_0000000E; op_done rises after E66 and stays high 10 further cycles without op_clear.
- Signed build, -100 / 7 -> quotient 32'hFFFFFFF2, remainder 32'hFFFFFFFE. Also 100 / -7 -> quotient 32'hFFFFFFF2, remainder 32'h00000002.
- 32'h80000000 / 32'hFFFFFFFF:
  - Signed build: result = 64'h00000000_80000000.
  - Unsigned build: result = 64'h80000000_00000000.
- 12345 / 0 -> result = 64'h00003039_FFFFFFFF; op_done high after E1.
- op_clear at edge E21 (mid-iteration) -> op_done = 0, result = 0, IDLE next cycle. Then 20 / 3 -> result = 64'h00000002_00000006 after E66.
- reset pulsed at E40 with op_start held high -> all outputs 0 after the reset edge. A new operation starts on the first edge after reset deasserts, and op_done asserts 66 edges later.
